// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA execute-stage modular multiplier.
package rsa_pkg;

    // Default operand/result width.
    localparam int unsigned DEF_DATA_W = 32;

    // Width of the internal scratch datapath. Any DATA_W below this fits, with
    // room for the extra carry bit of 2*acc and t+a.
    localparam int unsigned MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } modmul_state_t;

    // Single conditional subtract. Operands are always below 2n, so one
    // subtraction brings the value back into [0, n).
    function automatic logic [MAX_W:0] cond_sub(input logic [MAX_W:0] x,
                                                input logic [MAX_W:0] n);
        return (x >= n) ? (x - n) : x;
    endfunction

endpackage

// File: rtl/modmul_step.sv
// One MSB-first iteration of interleaved modular multiplication:
// acc_next = (2*acc + (b_bit ? a : 0)) mod n, given acc < n and a < n.
module modmul_step
    import rsa_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] n,
    input  logic              b_bit,
    output logic [DATA_W-1:0] acc_next
);

    localparam int unsigned PAD_W = MAX_W - DATA_W;

    logic [MAX_W:0] n_ext;
    logic [MAX_W:0] a_ext;
    logic [MAX_W:0] dbl;
    logic [MAX_W:0] t;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] u;
    logic           unused_hi;

    // Double, reduce, optionally add a, reduce again; carry bit kept so 2*acc never overflows.
    always_comb begin
        n_ext = {{PAD_W{1'b0}}, 1'b0, n};
        a_ext = {{PAD_W{1'b0}}, 1'b0, a};
        dbl   = {{PAD_W{1'b0}}, acc, 1'b0};
        t     = cond_sub(dbl, n_ext);
        sum   = t + a_ext;
        u     = b_bit ? cond_sub(sum, n_ext) : t;
    end

    assign acc_next = u[DATA_W-1:0];

    // Bits above DATA_W-1 are always zero once reduced below n.
    assign unused_hi = ^u[MAX_W:DATA_W];

endmodule

// File: rtl/ex_modmul_unit.sv
// Multi-cycle execute-stage unit computing (a*b) mod n, one multiplier bit per
// cycle, stalling the upstream pipeline while it iterates.
module ex_modmul_unit
    import rsa_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startE,
    input  logic [DATA_W-1:0] aE,
    input  logic [DATA_W-1:0] bE,
    input  logic [DATA_W-1:0] nE,
    input  logic [3:0]        wa3E,
    output logic              stallE,
    output logic              busyE,
    output logic              doneE,
    output logic              errE,
    output logic [DATA_W-1:0] resultE,
    output logic [3:0]        wa3OutE
);

    modmul_state_t     state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        wa3_q, wa3_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] acc_next;

    modmul_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .n        (n_q),
        .b_bit    (b_q[cnt_q]),
        .acc_next (acc_next)
    );

    // Next-state: accept/reject in IDLE, iterate in ITER, single-cycle DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        wa3_d    = wa3_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (startE) begin
                    wa3_d = wa3E;
                    if ((nE == '0) || (aE >= nE)) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        a_d     = aE;
                        b_d     = bE;
                        n_d     = nE;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        err_d   = 1'b0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                acc_d = acc_next;
                if (cnt_q == '0) begin
                    result_d = acc_next;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // A start seen here is dropped; the requester re-presents in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            wa3_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            wa3_q    <= wa3_d;
            err_q    <= err_d;
        end
    end

    // Status outputs decoded from state; stall is masked so it never asserts during reset.
    always_comb begin
        busyE  = (state_q == ITER);
        doneE  = (state_q == DONE);
        stallE = !rst && (((state_q == IDLE) && startE) || (state_q == ITER));
    end

    assign resultE = result_q;
    assign wa3OutE = wa3_q;
    assign errE    = err_q;

endmodule

// File: tb/tb_ex_modmul_unit.sv
// Self-checking bench for ex_modmul_unit: directed corner cases plus a random
// sweep checked against a plain-arithmetic modular multiply model.
module tb_ex_modmul_unit;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;

    logic          startE;
    logic [W-1:0]  aE, bE, nE;
    logic [3:0]    wa3E;
    logic          stallE, busyE, doneE, errE;
    logic [W-1:0]  resultE;
    logic [3:0]    wa3OutE;

    logic          startE8;
    logic [7:0]    aE8, bE8, nE8;
    logic [3:0]    wa3E8;
    logic          stallE8, busyE8, doneE8, errE8;
    logic [7:0]    resultE8;
    logic [3:0]    wa3OutE8;

    int vectors     = 0;
    int miscompares = 0;

    ex_modmul_unit #(
        .DATA_W (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .startE  (startE),
        .aE      (aE),
        .bE      (bE),
        .nE      (nE),
        .wa3E    (wa3E),
        .stallE  (stallE),
        .busyE   (busyE),
        .doneE   (doneE),
        .errE    (errE),
        .resultE (resultE),
        .wa3OutE (wa3OutE)
    );

    ex_modmul_unit #(
        .DATA_W (8)
    ) dut8 (
        .clk     (clk),
        .rst     (rst),
        .startE  (startE8),
        .aE      (aE8),
        .bE      (bE8),
        .nE      (nE8),
        .wa3E    (wa3E8),
        .stallE  (stallE8),
        .busyE   (busyE8),
        .doneE   (doneE8),
        .errE    (errE8),
        .resultE (resultE8),
        .wa3OutE (wa3OutE8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: (a*b) mod n from a full 64-bit product.
    task automatic ref_mm(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                          output logic err, output logic [31:0] res);
        logic [63:0] p;
        if (n == 32'd0 || a >= n) begin
            err = 1'b1;
            res = 32'd0;
        end else begin
            err = 1'b0;
            p   = ({32'd0, a} * {32'd0, b}) % {32'd0, n};
            res = p[31:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until doneE; stall must stay high on every earlier cycle.
    task automatic wait_done(input string tag, input int exp_edges);
        int edges    = 0;
        bit stall_ok = 1'b1;
        do begin
            tick();
            edges++;
            startE = 1'b0;
            if (!doneE && !stallE) stall_ok = 1'b0;
        end while (!doneE && edges < exp_edges + 10);
        chk({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        chk({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
        chk({tag, "_stall_in_done"}, 64'(stallE), 64'd0);
        chk({tag, "_busy_in_done"}, 64'(busyE), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] n, input logic [3:0] t);
        logic        e_err;
        logic [31:0] e_res;
        ref_mm(a, b, n, e_err, e_res);
        aE = a; bE = b; nE = n; wa3E = t; startE = 1'b1;
        #1;
        chk({tag, "_stall_accept"}, 64'(stallE), 64'd1);
        wait_done(tag, e_err ? 1 : W + 1);
        chk({tag, "_done"}, 64'(doneE), 64'd1);
        chk({tag, "_result"}, 64'(resultE), 64'(e_res));
        chk({tag, "_tag"}, 64'(wa3OutE), 64'(t));
        chk({tag, "_err"}, 64'(errE), 64'(e_err));
        tick();
        chk({tag, "_done_pulse"}, 64'(doneE), 64'd0);
        chk({tag, "_result_held"}, 64'(resultE), 64'(e_res));
    endtask

    initial begin
        int          e8;
        bit          ok8;
        bit          no_done;
        logic [31:0] ra, rb, rn;

        rst = 1'b1; startE = 1'b0; aE = '0; bE = '0; nE = '0; wa3E = '0;
        startE8 = 1'b0; aE8 = '0; bE8 = '0; nE8 = '0; wa3E8 = '0;
        tick();
        tick();
        chk("rst_stall", 64'(stallE), 64'd0);
        chk("rst_busy", 64'(busyE), 64'd0);
        chk("rst_done", 64'(doneE), 64'd0);
        chk("rst_err", 64'(errE), 64'd0);
        chk("rst_result", 64'(resultE), 64'd0);
        chk("rst_tag", 64'(wa3OutE), 64'd0);
        rst = 1'b0;
        tick();

        // 8-bit instance: 7*9 mod 11 = 8, done after edge 9.
        aE8 = 8'd7; bE8 = 8'd9; nE8 = 8'd11; wa3E8 = 4'd3; startE8 = 1'b1;
        #1;
        chk("w8_stall_accept", 64'(stallE8), 64'd1);
        e8 = 0; ok8 = 1'b1;
        do begin
            tick();
            e8++;
            startE8 = 1'b0;
            if (!doneE8 && !stallE8) ok8 = 1'b0;
        end while (!doneE8 && e8 < 30);
        chk("w8_edges", 64'(e8), 64'd9);
        chk("w8_stall_held", 64'(ok8), 64'd1);
        chk("w8_result", 64'(resultE8), 64'd8);
        chk("w8_tag", 64'(wa3OutE8), 64'd3);
        chk("w8_err", 64'(errE8), 64'd0);
        tick();
        chk("w8_done_pulse", 64'(doneE8), 64'd0);

        // Largest operands: 2*acc needs the carry bit.
        run_op("ovf", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'd9);
        chk("ovf_const", 64'(resultE), 64'd1);
        run_op("basic", 32'd7, 32'd9, 32'd11, 4'd3);
        run_op("err_n0", 32'd5, 32'd3, 32'd0, 4'd12);
        run_op("err_aeqn", 32'h10, 32'd3, 32'h10, 4'd5);

        // Back-to-back: start held into DONE is ignored and accepted in the next IDLE.
        run_op("b2b_first", 32'd7, 32'd9, 32'd11, 4'd3);
        aE = 32'd5; bE = 32'd5; nE = 32'd7; wa3E = 4'd6; startE = 1'b1;
        run_op("b2b_pre", 32'd7, 32'd9, 32'd11, 4'd3);
        // run_op ends one cycle after done; restart the back-to-back sequence by hand.
        aE = 32'd7; bE = 32'd9; nE = 32'd11; wa3E = 4'd3; startE = 1'b1;
        wait_done("b2b_a", W + 1);
        aE = 32'd5; bE = 32'd5; nE = 32'd7; wa3E = 4'd6; startE = 1'b1;
        tick();
        chk("b2b_ignored_busy", 64'(busyE), 64'd0);
        chk("b2b_ignored_done", 64'(doneE), 64'd0);
        chk("b2b_first_held", 64'(resultE), 64'd8);
        chk("b2b_stall_idle", 64'(stallE), 64'd1);
        tick();
        startE = 1'b0;
        chk("b2b_accept_busy", 64'(busyE), 64'd1);
        chk("b2b_held_at_accept", 64'(resultE), 64'd8);
        wait_done("b2b_second", W);
        chk("b2b_second_result", 64'(resultE), 64'd4);
        chk("b2b_second_tag", 64'(wa3OutE), 64'd6);
        tick();

        // Reset while iterating with cnt=4: everything clears, no done follows.
        aE = 32'd7; bE = 32'd9; nE = 32'd11; wa3E = 4'd3; startE = 1'b1;
        tick();
        startE = 1'b0;
        repeat (27) tick();
        chk("mid_busy", 64'(busyE), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 64'(stallE), 64'd0);
        chk("mid_rst_busy", 64'(busyE), 64'd0);
        chk("mid_rst_done", 64'(doneE), 64'd0);
        chk("mid_rst_err", 64'(errE), 64'd0);
        chk("mid_rst_result", 64'(resultE), 64'd0);
        chk("mid_rst_tag", 64'(wa3OutE), 64'd0);
        tick();
        rst = 1'b0;
        no_done = 1'b1;
        repeat (8) begin
            tick();
            if (doneE || busyE) no_done = 1'b0;
        end
        chk("mid_no_done", 64'(no_done), 64'd1);
        run_op("after_rst", 32'd7, 32'd9, 32'd11, 4'd3);

        // Random sweep with rotating corner classes.
        for (int i = 0; i < 24; i++) begin
            rn = $urandom();
            if (rn == 32'd0) rn = 32'd1;
            ra = $urandom() % rn;
            rb = $urandom();
            case (i % 6)
                1: rb = 32'd0;
                2: ra = 32'd0;
                3: begin rb = 32'd1; ra = rn - 32'd1; end
                4: begin rn = $urandom_range(1, 255); ra = $urandom() % rn; end
                5: begin rn = $urandom_range(1, 1000); ra = rn + $urandom_range(0, 1000); end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), ra, rb, rn, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
